// File: rtl/stream_demux.sv
// One-beat stream demultiplexer: routes each input beat to one channel or a broadcast set,
// retiring it once every addressed channel has taken it; beats with no destination are dropped.
module stream_demux #(
  parameter int unsigned NUM_OUTPUTS = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic [$clog2(NUM_OUTPUTS)-1:0] i_select,
  input  logic                       i_bcast,
  input  logic [NUM_OUTPUTS-1:0]     i_bcast_mask,
  output logic [NUM_OUTPUTS-1:0]     o_valid,
  input  logic [NUM_OUTPUTS-1:0]     i_ready,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_drop,
  output logic [CNT_WIDTH-1:0]       o_drop_count
);

  localparam int unsigned SELECT_BITS = $clog2(NUM_OUTPUTS);

  typedef enum logic {StEmpty, StHold} state_e;

  logic [DATA_WIDTH-1:0]  data_q;
  logic [NUM_OUTPUTS-1:0] pend_q;
  logic                   drop_q;
  logic [CNT_WIDTH-1:0]   cnt_q;

  state_e                 state;
  logic [NUM_OUTPUTS-1:0] dest_sel;
  logic [NUM_OUTPUTS-1:0] dest;
  logic                   drain;
  logic                   ready;
  logic                   handshake;

  always_comb begin
    // Out-of-range selects match no channel and fall through to a drop.
    dest_sel = '0;
    for (int k = 0; k < int'(NUM_OUTPUTS); k++) begin
      if (i_select == SELECT_BITS'(k)) dest_sel[k] = 1'b1;
    end
    dest  = i_bcast ? i_bcast_mask : dest_sel;
    drain = ((pend_q & ~i_ready) == '0);
    state = (pend_q == '0) ? StEmpty : StHold;
    unique case (state)
      StEmpty: ready = 1'b1;
      StHold:  ready = drain;
      default: ready = 1'b1;
    endcase
    handshake = i_valid & ready;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q <= '0;
      pend_q <= '0;
      drop_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      drop_q <= 1'b0;
      if (handshake) begin
        if (dest != '0) begin
          data_q <= i_data;
          pend_q <= dest;
        end else begin
          pend_q <= '0;
          drop_q <= 1'b1;
          if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        pend_q <= pend_q & ~i_ready;
      end
    end
  end

  assign o_ready      = ready;
  assign o_valid      = pend_q;
  assign o_data       = data_q;
  assign o_drop       = drop_q;
  assign o_drop_count = cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed and randomized checks of stream_demux against a beat-level reference model.
module tb_stream_demux;

  localparam int N   = 5;
  localparam int DW  = 16;
  localparam int CW  = 3;
  localparam int SB  = 3;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  logic          o_ready;
  logic [DW-1:0] data;
  logic [SB-1:0] sel;
  logic          bcast;
  logic [N-1:0]  mask;
  logic [N-1:0]  o_valid;
  logic [N-1:0]  rdy;
  logic [DW-1:0] o_data;
  logic          o_drop;
  logic [CW-1:0] o_drop_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: which channels still owe the held beat, its payload, drop bookkeeping.
  logic [N-1:0]  m_pend;
  logic [DW-1:0] m_data;
  int            m_cnt;
  logic          m_drop;

  stream_demux #(.NUM_OUTPUTS(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid),
    .o_ready      (o_ready),
    .i_data       (data),
    .i_select     (sel),
    .i_bcast      (bcast),
    .i_bcast_mask (mask),
    .o_valid      (o_valid),
    .i_ready      (rdy),
    .o_data       (o_data),
    .o_drop       (o_drop),
    .o_drop_count (o_drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic model_ready();
    // A new beat fits when nothing is owed or every owing channel takes it now.
    int owed = 0;
    for (int k = 0; k < N; k++) if (m_pend[k] && !rdy[k]) owed++;
    return owed == 0;
  endfunction

  function automatic logic [N-1:0] dest_of(input logic b, input logic [N-1:0] m,
                                           input logic [SB-1:0] s);
    if (b) return m;
    if (int'(s) < N) return N'(1) << s;
    return '0;
  endfunction

  task automatic drive(input logic v, input logic [SB-1:0] s, input logic b,
                       input logic [N-1:0] m, input logic [DW-1:0] d, input logic [N-1:0] r);
    valid = v; sel = s; bcast = b; mask = m; data = d; rdy = r;
  endtask

  task automatic tick();
    logic [N-1:0] d;
    m_drop = 1'b0;
    if (valid && model_ready()) begin
      d = dest_of(bcast, mask, sel);
      if (d != '0) begin
        m_pend = d;
        m_data = data;
      end else begin
        m_pend = '0;
        m_drop = 1'b1;
        if (m_cnt < MAX) m_cnt++;
      end
    end else begin
      for (int k = 0; k < N; k++) if (rdy[k]) m_pend[k] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pend = '0; m_data = '0; m_cnt = 0; m_drop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    #2;
    checks++; if (o_valid !== '0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", o_data); end
    checks++; if (o_drop_count !== '0 || o_drop !== 1'b0) begin failures++;
      $display("FAIL reset_drop got=%b/%0d exp=0/0", o_drop, o_drop_count); end
    #5 rst_n = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    tick();
  endtask

  task automatic test_unicast();
    drive(1'b1, 3'd2, 1'b0, '0, 16'h00A5, '0);
    #1;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL uni_accept got=%b exp=1", o_ready); end
    tick();
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    #1;
    checks++; if (o_valid !== 5'b00100 || o_data !== 16'h00A5 || o_ready !== 1'b0) begin failures++;
      $display("FAIL uni_hold got=%b/%h/%b exp=00100/00a5/0", o_valid, o_data, o_ready); end
    rdy = 5'b00100;
    #1;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL uni_drain got=%b exp=1", o_ready); end
    tick();
    rdy = '0;
    #1;
    checks++; if (o_valid !== '0) begin failures++; $display("FAIL uni_retire got=%b exp=0", o_valid); end
  endtask

  task automatic test_drop();
    drive(1'b1, 3'd7, 1'b0, '0, 16'h1234, '0);
    #1;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL drop_accept got=%b exp=1", o_ready); end
    tick();
    valid = 1'b0;
    #1;
    checks++; if (o_drop !== 1'b1 || o_drop_count !== 3'd1 || o_valid !== '0) begin failures++;
      $display("FAIL drop_pulse got=%b/%0d/%b exp=1/1/0", o_drop, o_drop_count, o_valid); end
    checks++; if (o_data !== 16'h00A5) begin failures++; $display("FAIL drop_data got=%h exp=00a5", o_data); end
    tick();
    checks++; if (o_drop !== 1'b0) begin failures++; $display("FAIL drop_once got=%b exp=0", o_drop); end
  endtask

  task automatic test_bcast_mask_zero();
    drive(1'b1, 3'd1, 1'b1, '0, 16'h5555, '1);
    tick();
    valid = 1'b0;
    #1;
    checks++; if (o_drop !== 1'b1 || o_drop_count !== 3'd2 || o_valid !== '0) begin failures++;
      $display("FAIL bzero got=%b/%0d/%b exp=1/2/0", o_drop, o_drop_count, o_valid); end
    tick();
  endtask

  task automatic test_saturate();
    drive(1'b1, 3'd6, 1'b0, '0, '0, '0);
    for (int i = 0; i < 7; i++) tick();
    valid = 1'b0;
    #1;
    checks++; if (o_drop_count !== 3'd7) begin failures++;
      $display("FAIL saturate got=%0d exp=7", o_drop_count); end
    tick();
  endtask

  task automatic test_broadcast();
    drive(1'b1, 3'd0, 1'b1, 5'b01011, 16'h003C, '0);
    tick();
    drive(1'b0, '0, 1'b0, '0, '0, 5'b00001);
    #1;
    checks++; if (o_valid !== 5'b01011 || o_data !== 16'h003C || o_ready !== 1'b0) begin failures++;
      $display("FAIL bc_c1 got=%b/%h/%b exp=01011/003c/0", o_valid, o_data, o_ready); end
    tick();
    rdy = 5'b01000;
    #1;
    checks++; if (o_valid !== 5'b01010 || o_ready !== 1'b0) begin failures++;
      $display("FAIL bc_c2 got=%b/%b exp=01010/0", o_valid, o_ready); end
    tick();
    rdy = 5'b00010;
    #1;
    checks++; if (o_valid !== 5'b00010 || o_ready !== 1'b1) begin failures++;
      $display("FAIL bc_c3 got=%b/%b exp=00010/1", o_valid, o_ready); end
    tick();
    rdy = '0;
    #1;
    checks++; if (o_valid !== '0) begin failures++; $display("FAIL bc_c4 got=%b exp=0", o_valid); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 3'd0, 1'b0, '0, 16'h0001, '1);
    tick();
    for (int i = 1; i <= 3; i++) begin
      if (i < 3) begin sel = SB'(i); data = DW'(i + 1); end
      else valid = 1'b0;
      #1;
      checks++;
      if (o_valid !== (N'(1) << (i - 1)) || o_data !== DW'(i) || o_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_%0d got=%b/%h/%b exp=%b/%h/1", i, o_valid, o_data, o_ready,
                 N'(1) << (i - 1), DW'(i));
      end
      tick();
    end
    checks++; if (o_valid !== '0) begin failures++; $display("FAIL b2b_end got=%b exp=0", o_valid); end
  endtask

  task automatic test_reset_mid_beat();
    drive(1'b1, 3'd3, 1'b0, '0, 16'hBEEF, '0);
    tick();
    valid = 1'b0;
    #1;
    checks++; if (o_valid !== 5'b01000) begin failures++; $display("FAIL rst_hold got=%b exp=01000", o_valid); end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (o_valid !== '0 || o_drop_count !== '0) begin failures++;
      $display("FAIL rst_async got=%b/%0d exp=0/0", o_valid, o_drop_count); end
    #2 rst_n = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", o_ready); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      valid = ($urandom_range(0, 3) != 0);
      sel   = SB'($urandom_range(0, 7));
      bcast = ($urandom_range(0, 3) == 0);
      mask  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      data  = DW'($urandom);
      rdy   = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom);
      #1;
      checks++;
      if (o_ready !== model_ready() || o_valid !== m_pend || o_data !== m_data ||
          o_drop !== m_drop || o_drop_count !== CW'(m_cnt)) begin
        failures++;
        $display("FAIL rand_%0d got rdy=%b v=%b d=%h dr=%b c=%0d exp rdy=%b v=%b d=%h dr=%b c=%0d",
                 i, o_ready, o_valid, o_data, o_drop, o_drop_count,
                 model_ready(), m_pend, m_data, m_drop, m_cnt);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_drop();
    test_bcast_mask_zero();
    test_saturate();
    test_broadcast();
    test_back_to_back();
    test_reset_mid_beat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
